can_bit_destuffer: RTL

- Parametrised successor to the CAN bit-stuff error checker. Runs on the bit-time sample point SP.
- Tracks runs of equal bits while stuffing is active and flags every stuff bit so downstream logic can drop it.
- Detects and latches stuff errors, and keeps a running stuff-bit count for the CAN FD stuff-count field.
- Sits between the bit-timing/sampling logic and the frame decoder FSM.

---
 rtl/can_bit_destuffer_if.sv | 23 ++
 rtl/can_bit_destuffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer_if.sv
// Bus bundle between the bit sampler / frame decoder and the CAN bit destuffer.
// master drives the sampled bit and window controls, slave is the destuffer.
interface can_bit_destuffer_if;
   logic       RX;
   logic       F_STF;
   logic       ERR_CLR;
   logic       DOUT;
   logic       DVALID;
   logic       DESTUFF;
   logic       STF_ERR;
   logic [2:0] STF_CNT;
   logic [3:0] STF_GRAY;

   modport master (
      output RX, F_STF, ERR_CLR,
      input  DOUT, DVALID, DESTUFF, STF_ERR, STF_CNT, STF_GRAY
   );

   modport slave (
      input  RX, F_STF, ERR_CLR,
      output DOUT, DVALID, DESTUFF, STF_ERR, STF_CNT, STF_GRAY
   );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: flags stuff bits, latches stuff errors, counts stuff bits per window.
// Optional macro CAN_STF_GRAY_EN adds the Gray-coded stuff count with parity on STF_GRAY.
module can_bit_destuffer #(
   parameter int STUFF_LEN = 5,
   parameter int RUN_W     = 4
) (
   input logic                SP,
   input logic                reset,
   can_bit_destuffer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COUNT, EXPECT, ERROR} state_t;

   localparam logic [RUN_W-1:0] STUFF_LEN_W = RUN_W'(STUFF_LEN);
   localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

   state_t           state;
   logic [RUN_W-1:0] run_len;
   logic             last_bit;
   logic             dout;
   logic             dvalid;
   logic             destuff;
   logic             stf_err;
   logic [2:0]       stf_cnt;
   logic [2:0]       cnt_next;

   // Next stuff count is shared by the FSM and the optional Gray encoder so both stay in step.
   always_comb begin
      cnt_next = stf_cnt;
      if (!bus.F_STF) begin
         cnt_next = 3'd0;
      end else begin
         case (state)
            IDLE:    cnt_next = 3'd0;
            EXPECT:  if (bus.RX != last_bit) cnt_next = stf_cnt + 3'd1;
            ERROR:   if (bus.ERR_CLR) cnt_next = 3'd0;
            default: cnt_next = stf_cnt;
         endcase
      end
   end

   always_ff @(posedge SP) begin
      if (!reset) begin
         state    <= IDLE;
         run_len  <= '0;
         last_bit <= 1'b1;
         dout     <= 1'b1;
         dvalid   <= 1'b0;
         destuff  <= 1'b0;
         stf_err  <= 1'b0;
         stf_cnt  <= 3'd0;
      end else begin
         dout    <= bus.RX;
         destuff <= 1'b0;
         stf_cnt <= cnt_next;
         if (!bus.F_STF) begin
            state   <= IDLE;
            run_len <= '0;
            dvalid  <= 1'b0;
            stf_err <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= COUNT;
                  last_bit <= bus.RX;
                  run_len  <= RUN_ONE;
                  dvalid   <= 1'b1;
               end
               COUNT: begin
                  dvalid <= 1'b1;
                  if (bus.RX == last_bit) begin
                     run_len <= run_len + RUN_ONE;
                     if (run_len + RUN_ONE == STUFF_LEN_W) state <= EXPECT;
                  end else begin
                     last_bit <= bus.RX;
                     run_len  <= RUN_ONE;
                  end
               end
               // The stuff bit opens the next run, so counting restarts at one.
               EXPECT: begin
                  dvalid <= 1'b0;
                  if (bus.RX != last_bit) begin
                     destuff  <= 1'b1;
                     last_bit <= bus.RX;
                     run_len  <= RUN_ONE;
                     state    <= COUNT;
                  end else begin
                     stf_err <= 1'b1;
                     state   <= ERROR;
                  end
               end
               ERROR: begin
                  dvalid <= 1'b0;
                  if (bus.ERR_CLR) begin
                     stf_err <= 1'b0;
                     run_len <= '0;
                     state   <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.DOUT    = dout;
   assign bus.DVALID  = dvalid;
   assign bus.DESTUFF = destuff;
   assign bus.STF_ERR = stf_err;
   assign bus.STF_CNT = stf_cnt;

`ifdef CAN_STF_GRAY_EN
   logic [3:0] stf_gray;
   logic [2:0] gray_next;

   assign gray_next = cnt_next ^ (cnt_next >> 1);

   // Bit 3 is set when the Gray code holds an even number of ones.
   always_ff @(posedge SP) begin
      if (!reset) stf_gray <= 4'd0;
      else        stf_gray <= {~^gray_next, gray_next};
   end

   assign bus.STF_GRAY = stf_gray;
`else
   assign bus.STF_GRAY = 4'd0;
`endif

endmodule
